midi_writer: RTL and testbench

- MIDI transmitter: the outbound counterpart of midi_reader.
- Accepts a parsed channel message (status nibble, channel, two data bytes) over a valid/ready handshake.
- Serializes it as a 2- or 3-byte MIDI message on a 31250-baud 8N1 UART line.
- Drives external synths and loops back into midi_reader for self-test; optional running-status compression.

---
 rtl/midi_writer.sv | 147 ++++++++++++++
 tb/tb_midi_writer.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/midi_writer.sv
// midi_writer: MIDI channel-message transmitter (8N1 UART, LSB first).
// A parsed message (status nibble, channel, two data bytes) is accepted on
// valid_in && ready_out and shifted out as 2 or 3 bytes, back to back with
// no inter-byte gap. With RUNNING_STATUS=1 the status byte is dropped when
// it repeats the last transmitted status byte.
// Ports:
//   clk_in, rst_in            clock, async active-low reset
//   status_in, channel_in     message type nibble, MIDI channel
//   data_byte1_in/2_in        data bytes (bit 7 masked on transmit)
//   valid_in / ready_out      request handshake
//   tx_wire_out               serial line, idle high
//   busy_out                  high while a message is being shifted
//   done_out                  one-cycle pulse after the last stop bit
//   error_out                 one-cycle pulse when a status is rejected
module midi_writer #(
  parameter int CLK_HZ         = 100_000_000,
  parameter int BAUD           = 31_250,
  parameter int CYCLES_PER_BIT = CLK_HZ / BAUD,
  parameter bit RUNNING_STATUS = 1'b0
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic [3:0] status_in,
  input  logic [3:0] channel_in,
  input  logic [7:0] data_byte1_in,
  input  logic [7:0] data_byte2_in,
  input  logic       valid_in,
  output logic       ready_out,
  output logic       tx_wire_out,
  output logic       busy_out,
  output logic       done_out,
  output logic       error_out
);

  localparam int CW = $clog2(CYCLES_PER_BIT);
  localparam logic [CW-1:0] CNT_MAX = CW'(CYCLES_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [1:0]    left;       // bytes still to send, including the current one
  logic [23:0]   msg;        // current byte always sits in msg[7:0]
  logic [7:0]    last_status;

  logic [7:0] sb, d1m, d2m;
  logic       len3, len2, skip, bit_end;
  logic [2:0] nxt_bit;

  assign sb      = {status_in, channel_in};
  assign d1m     = data_byte1_in & 8'h7F;
  assign d2m     = data_byte2_in & 8'h7F;
  assign len3    = (status_in inside {4'h8, 4'h9, 4'hA, 4'hB, 4'hE});
  assign len2    = (status_in inside {4'hC, 4'hD});
  // last_status resets to 0x00, which never matches a legal status byte
  assign skip    = RUNNING_STATUS && (sb == last_status);
  assign bit_end = (cnt == CNT_MAX);
  assign nxt_bit = bit_idx + 3'd1;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state       <= IDLE;
      cnt         <= '0;
      bit_idx     <= '0;
      left        <= '0;
      msg         <= '0;
      last_status <= 8'h00;
      tx_wire_out <= 1'b1;
      ready_out   <= 1'b1;
      busy_out    <= 1'b0;
      done_out    <= 1'b0;
      error_out   <= 1'b0;
    end else begin
      done_out  <= 1'b0;
      error_out <= 1'b0;
      case (state)
        IDLE: begin
          if (valid_in) begin
            if (!(len2 || len3)) begin
              error_out <= 1'b1;
            end else begin
              if (skip) begin
                msg  <= {8'h00, d2m, d1m};
                left <= len3 ? 2'd2 : 2'd1;
              end else begin
                msg         <= {d2m, d1m, sb};
                left        <= len3 ? 2'd3 : 2'd2;
                last_status <= sb;
              end
              state       <= START;
              cnt         <= '0;
              tx_wire_out <= 1'b0;
              ready_out   <= 1'b0;
              busy_out    <= 1'b1;
            end
          end
        end
        START: begin
          if (bit_end) begin
            cnt         <= '0;
            bit_idx     <= '0;
            state       <= DATA;
            tx_wire_out <= msg[0];
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DATA: begin
          if (bit_end) begin
            cnt <= '0;
            if (bit_idx == 3'd7) begin
              state       <= STOP;
              tx_wire_out <= 1'b1;
            end else begin
              bit_idx     <= nxt_bit;
              tx_wire_out <= msg[nxt_bit];
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        STOP: begin
          if (bit_end) begin
            cnt <= '0;
            if (left > 2'd1) begin
              left        <= left - 2'd1;
              msg         <= {8'h00, msg[23:8]};
              state       <= START;
              tx_wire_out <= 1'b0;
            end else begin
              // ready returns with done so a new accept can follow at once
              state     <= IDLE;
              ready_out <= 1'b1;
              busy_out  <= 1'b0;
              done_out  <= 1'b1;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_midi_writer.sv
// Directed bench for midi_writer at CYCLES_PER_BIT=16. Instance 0 runs
// without running status, instance 1 with it. The serial line is sampled at
// mid-bit relative to the accept edge and each frame is decoded and compared
// against hand-computed bytes.
module tb_midi_writer;
  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] st, ch;
  logic [7:0] d1, d2;
  logic [1:0] valid, ready, tx, busy, done, error;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  midi_writer #(.CYCLES_PER_BIT(CPB), .RUNNING_STATUS(1'b0)) dut0 (
    .clk_in(clk), .rst_in(rst_n), .status_in(st), .channel_in(ch),
    .data_byte1_in(d1), .data_byte2_in(d2), .valid_in(valid[0]),
    .ready_out(ready[0]), .tx_wire_out(tx[0]), .busy_out(busy[0]),
    .done_out(done[0]), .error_out(error[0]));

  midi_writer #(.CYCLES_PER_BIT(CPB), .RUNNING_STATUS(1'b1)) dut1 (
    .clk_in(clk), .rst_in(rst_n), .status_in(st), .channel_in(ch),
    .data_byte1_in(d1), .data_byte2_in(d2), .valid_in(valid[1]),
    .ready_out(ready[1]), .tx_wire_out(tx[1]), .busy_out(busy[1]),
    .done_out(done[1]), .error_out(error[1]));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Present a message and pulse valid across one rising edge; returns #1
  // after the accept edge.
  task automatic send(input int s, input logic [3:0] s_st, input logic [3:0] s_ch,
                      input logic [7:0] s_d1, input logic [7:0] s_d2);
    chk("ready_pre", ready[s], 1'b1);
    st = s_st; ch = s_ch; d1 = s_d1; d2 = s_d2;
    valid[s] = 1'b1;
    @(posedge clk);
    #1 valid[s] = 1'b0;
  endtask

  // Decode n frames starting at the accept edge, then check the done pulse
  // lands exactly n*10*CPB edges after accept. Ends on the negedge of the
  // done cycle. tog toggles valid and scrambles inputs while busy.
  task automatic rx_msg(input int s, input int n, input logic [7:0] b0,
                        input logic [7:0] b1, input logic [7:0] b2, input bit tog);
    logic [7:0] exp [3];
    logic [9:0] fr;
    exp[0] = b0; exp[1] = b1; exp[2] = b2;
    for (int b = 0; b < n; b++) begin
      for (int k = 0; k < 10; k++) begin
        repeat ((b == 0 && k == 0) ? CPB / 2 : CPB) @(posedge clk);
        @(negedge clk);
        fr[k] = tx[s];
        chk("busy_mid", busy[s], 1'b1);
        chk("ready_mid", ready[s], 1'b0);
        if (tog) begin
          valid[s] = (k % 2 == 1) && !(b == n - 1 && k == 9);
          st = 4'h8; ch = 4'hF; d1 = 8'h55; d2 = 8'hAA;
        end
      end
      chk("start_bit", fr[0], 1'b0);
      chk("stop_bit", fr[9], 1'b1);
      chk($sformatf("byte%0d", b), fr[8:1], exp[b]);
    end
    repeat (CPB / 2 - 1) @(posedge clk);
    @(negedge clk);
    chk("done_early", done[s], 1'b0);
    chk("busy_last", busy[s], 1'b1);
    @(posedge clk);
    @(negedge clk);
    chk("done_pulse", done[s], 1'b1);
    chk("ready_done", ready[s], 1'b1);
    chk("busy_done", busy[s], 1'b0);
    chk("err_done", error[s], 1'b0);
    chk("tx_done", tx[s], 1'b1);
  endtask

  task automatic idle_chk(input int s);
    @(posedge clk);
    @(negedge clk);
    chk("done_clr", done[s], 1'b0);
    chk("tx_idle", tx[s], 1'b1);
  endtask

  task automatic bad_status(input logic [3:0] s_st);
    send(0, s_st, 4'h2, 8'h11, 8'h22);
    chk("err_pulse", error[0], 1'b1);
    chk("err_ready", ready[0], 1'b1);
    chk("err_busy", busy[0], 1'b0);
    chk("err_tx", tx[0], 1'b1);
    chk("err_done", done[0], 1'b0);
    @(posedge clk);
    #1;
    chk("err_clr", error[0], 1'b0);
    chk("err_tx2", tx[0], 1'b1);
    chk("err_busy2", busy[0], 1'b0);
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; valid = 2'b00;
    st = '0; ch = '0; d1 = '0; d2 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      chk("rst_tx", tx[s], 1'b1);
      chk("rst_ready", ready[s], 1'b1);
      chk("rst_busy", busy[s], 1'b0);
      chk("rst_done", done[s], 1'b0);
      chk("rst_err", error[s], 1'b0);
    end
    rst_n = 1'b1;
    @(negedge clk);

    // note-on 0x90 3C 64, 3 bytes, done 480 edges after accept
    send(0, 4'h9, 4'h0, 8'h3C, 8'h64);
    rx_msg(0, 3, 8'h90, 8'h3C, 8'h64, 1'b0);
    idle_chk(0);

    // program change: two bytes, d2 ignored
    send(0, 4'hC, 4'h5, 8'h07, 8'h2A);
    rx_msg(0, 2, 8'hC5, 8'h07, 8'h00, 1'b0);
    idle_chk(0);

    // running status, back to back
    send(1, 4'h9, 4'h1, 8'h40, 8'h7F);
    rx_msg(1, 3, 8'h91, 8'h40, 8'h7F, 1'b0);
    send(1, 4'h9, 4'h1, 8'h41, 8'h7F);
    rx_msg(1, 2, 8'h41, 8'h7F, 8'h00, 1'b0);
    send(1, 4'h8, 4'h1, 8'h40, 8'h00);
    rx_msg(1, 3, 8'h81, 8'h40, 8'h00, 1'b0);
    idle_chk(1);

    // rejected status nibbles
    bad_status(4'hF);
    bad_status(4'h3);

    // bit 7 masking, valid toggled while busy
    send(0, 4'h9, 4'h0, 8'hBC, 8'hE4);
    rx_msg(0, 3, 8'h90, 8'h3C, 8'h64, 1'b1);
    idle_chk(0);

    // reset mid-data of byte 2 clears running status
    send(1, 4'h9, 4'h0, 8'h3C, 8'h64);
    rx_msg(1, 3, 8'h90, 8'h3C, 8'h64, 1'b0);
    idle_chk(1);
    send(1, 4'h9, 4'h0, 8'h3C, 8'h64);   // 3C 64 only; bit 1 of 0x64 is 0
    repeat (200) @(posedge clk);
    #2;
    chk("pre_rst_tx", tx[1], 1'b0);
    rst_n = 1'b0;
    #1;
    chk("arst_tx", tx[1], 1'b1);
    chk("arst_ready", ready[1], 1'b1);
    chk("arst_busy", busy[1], 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send(1, 4'h9, 4'h0, 8'h3C, 8'h64);
    rx_msg(1, 3, 8'h90, 8'h3C, 8'h64, 1'b0);
    idle_chk(1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // watchdog: every wait above is a fixed cycle count, this only guards the clock
  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "timeout");
  end
endmodule
